// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel pixel SRAM: word geometry and the writer FSM encoding.
// Also used by the sobel read scheduler.
package sobel_pkg;

   localparam int ADDR_W    = 20;
   localparam int DATA_W    = 64;
   localparam int PIX_W     = 8;
   localparam int ROW_WORDS = 256;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PACK = 2'b01,
      LAST = 2'b10,
      DONE = 2'b11
   } wr_state_t;

   // Counter width that stays legal for a count of one.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sram_row_writer_packer.sv
// Gathers DATA_W/PIX_W pixels into one SRAM word, lane 0 in the least significant bits.
// The word is presented combinationally on the same cycle its final lane is accepted.
module pixel_packer #(
   parameter int DATA_W = 64,
   parameter int PIX_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              take,
   input  logic [PIX_W-1:0]  pix_in,
   output logic              word_valid,
   output logic [DATA_W-1:0] word,
   output logic              last_lane
);
   import sobel_pkg::*;

   localparam int LANES  = DATA_W / PIX_W;
   localparam int LANE_W = cnt_width(LANES);

   logic [LANE_W-1:0] lane_p0;
   logic [DATA_W-1:0] pack_p0;

   assign last_lane  = (lane_p0 == LANE_W'(LANES - 1));
   assign word_valid = take & last_lane;
   // The top lane bypasses the pack register so the lane counter can wrap without a bubble.
   assign word       = {pix_in, pack_p0[DATA_W-PIX_W-1:0]};

   // ---- stage p0: lane counter and pack register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_p0 <= '0;
         pack_p0 <= '0;
      end else if (clear) begin
         lane_p0 <= '0;
         pack_p0 <= '0;
      end else if (take) begin
         pack_p0[lane_p0*PIX_W +: PIX_W] <= pix_in;
         lane_p0 <= last_lane ? '0 : lane_p0 + 1'b1;
      end
   end

endmodule

// File: rtl/sram_row_writer.sv
// Writer side of the row-major pixel SRAM: packs a frame of pixels into words and
// writes them at linear addresses BASE_ADDR + row*ROW_WORDS + col.
module sram_row_writer #(
   parameter int ADDR_W    = sobel_pkg::ADDR_W,
   parameter int DATA_W    = sobel_pkg::DATA_W,
   parameter int PIX_W     = sobel_pkg::PIX_W,
   parameter int ROW_WORDS = sobel_pkg::ROW_WORDS,
   parameter int NUM_ROWS  = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              startEn,
   input  logic [PIX_W-1:0]  pix_in,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              we,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              frame_done
);
   import sobel_pkg::*;

   localparam int COL_W = cnt_width(ROW_WORDS);
   localparam int ROW_W = cnt_width(NUM_ROWS);

   if (DATA_W != 8 * PIX_W) begin : g_width_check
      $error("sram_row_writer: DATA_W must equal 8*PIX_W");
   end

   wr_state_t state, state_nxt;

   logic              take;
   logic              clear;
   logic              word_valid;
   logic              last_lane;
   logic [DATA_W-1:0] word;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic              col_wrap;
   logic              row_last;
   logic              frame_end;
   logic [ADDR_W-1:0] addr_nxt;

   assign take      = pix_valid & pix_ready;
   assign col_wrap  = (col == COL_W'(ROW_WORDS - 1));
   assign row_last  = (row == ROW_W'(NUM_ROWS - 1));
   assign frame_end = take & last_lane & col_wrap & row_last;
   assign addr_nxt  = ADDR_W'(BASE_ADDR) + ADDR_W'(row) * ADDR_W'(ROW_WORDS) + ADDR_W'(col);

   pixel_packer #(
      .DATA_W (DATA_W),
      .PIX_W  (PIX_W)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .take       (take),
      .pix_in     (pix_in),
      .word_valid (word_valid),
      .word       (word),
      .last_lane  (last_lane)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      clear      = 1'b0;
      pix_ready  = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (startEn) begin
               state_nxt = PACK;
               clear     = 1'b1;
            end
         end
         PACK: begin
            pix_ready = 1'b1;
            busy      = 1'b1;
            if (frame_end) begin
               state_nxt = LAST;
            end
         end
         LAST: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Column advances per emitted word and carries into the row counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
      end else if (word_valid) begin
         if (col_wrap) begin
            col <= '0;
            row <= row_last ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // ---- stage p1: SRAM write port registers ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we         <= 1'b0;
         write_addr <= ADDR_W'(BASE_ADDR);
         data       <= '0;
      end else begin
         we <= word_valid;
         if (word_valid) begin
            write_addr <= addr_nxt;
            data       <= word;
         end
      end
   end

endmodule
